// File: rtl/dmem_responder.sv
// Word-organised data memory responder with req/ack handshake and WAIT_CYCLES wait states.
// Optional performance counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_pi,
    input  logic        reset_n_pi,
    input  logic        req_pi,
    input  logic        we_pi,
    input  logic [31:0] addr_pi,
    input  logic [31:0] wdata_pi,
    output logic        ack_po,
    output logic [31:0] rdata_po,
    output logic        err_po,
    output logic        busy_po
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] load_cnt_po,
    output logic [31:0] store_cnt_po,
    output logic [15:0] err_cnt_po
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] cap_idx;
    logic [AW-1:0] in_idx;
    logic          cap_bad;
    logic          in_bad;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    assign cap_idx = cap_addr[AW+1:2];
    assign in_idx  = addr_pi[AW+1:2];
    assign cap_bad = addr_bad(cap_addr);
    assign in_bad  = addr_bad(addr_pi);

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            ack_po    <= 1'b0;
            err_po    <= 1'b0;
            rdata_po  <= '0;
            busy_po   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
`ifdef DMEM_PERF_CNT_EN
            load_cnt_po  <= '0;
            store_cnt_po <= '0;
            err_cnt_po   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_pi) begin
                        cap_we    <= we_pi;
                        cap_addr  <= addr_pi;
                        cap_wdata <= wdata_pi;
                        busy_po   <= 1'b1;
                        // With no wait states the read happens on the accept edge,
                        // so it must use the live inputs rather than the captures.
                        if (WAIT_CYCLES == 0) begin
                            state    <= RESP;
                            ack_po   <= 1'b1;
                            err_po   <= in_bad;
                            rdata_po <= (we_pi || in_bad) ? '0 : mem[in_idx];
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= RESP;
                        ack_po   <= 1'b1;
                        err_po   <= cap_bad;
                        rdata_po <= (cap_we || cap_bad) ? '0 : mem[cap_idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy_po  <= 1'b0;
                    ack_po   <= 1'b0;
                    err_po   <= 1'b0;
                    rdata_po <= '0;
                    if (cap_we && !cap_bad) begin
                        mem[cap_idx] <= cap_wdata;
                    end
`ifdef DMEM_PERF_CNT_EN
                    if (cap_bad) begin
                        err_cnt_po <= err_cnt_po + 16'd1;
                    end else if (cap_we) begin
                        store_cnt_po <= store_cnt_po + 32'd1;
                    end else begin
                        load_cnt_po <= load_cnt_po + 32'd1;
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    busy_po <= 1'b0;
                    ack_po  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk_pi;
    logic        reset_n_pi;

    logic        req_a, we_a, ack_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ack_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] load_cnt_a, store_cnt_a, load_cnt_b, store_cnt_b;
    logic [15:0] err_cnt_a, err_cnt_b;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] model_a [256];
    logic [31:0] model_b [256];
    int unsigned m_load = 0, m_store = 0, m_err = 0;
    logic [31:0] addrs [8];

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk_pi(clk_pi), .reset_n_pi(reset_n_pi),
        .req_pi(req_a), .we_pi(we_a), .addr_pi(addr_a), .wdata_pi(wdata_a),
        .ack_po(ack_a), .rdata_po(rdata_a), .err_po(err_a), .busy_po(busy_a)
`ifdef DMEM_PERF_CNT_EN
        , .load_cnt_po(load_cnt_a), .store_cnt_po(store_cnt_a), .err_cnt_po(err_cnt_a)
`endif
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk_pi(clk_pi), .reset_n_pi(reset_n_pi),
        .req_pi(req_b), .we_pi(we_b), .addr_pi(addr_b), .wdata_pi(wdata_b),
        .ack_po(ack_b), .rdata_po(rdata_b), .err_po(err_b), .busy_po(busy_b)
`ifdef DMEM_PERF_CNT_EN
        , .load_cnt_po(load_cnt_b), .store_cnt_po(store_cnt_b), .err_cnt_po(err_cnt_b)
`endif
    );

    initial clk_pi = 1'b0;
    always #5 clk_pi = ~clk_pi;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
        m_load  = 0;
        m_store = 0;
        m_err   = 0;
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != '0);
    endfunction

    // Build the expectation from the reference model, then update the model.
    task automatic push_exp(input bit sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        exp_t        e;
        logic        bad;
        logic [7:0]  idx;
        bad   = is_bad(addr);
        idx   = addr[9:2];
        e.err = bad;
        if (sel) e.rdata = (we || bad) ? 32'h0 : model_b[idx];
        else     e.rdata = (we || bad) ? 32'h0 : model_a[idx];
        if (we && !bad) begin
            if (sel) model_b[idx] = wdata;
            else     model_a[idx] = wdata;
        end
        if (sel) begin
            q_b.push_back(e);
        end else begin
            q_a.push_back(e);
            if (bad)     m_err++;
            else if (we) m_store++;
            else         m_load++;
        end
    endtask

    task automatic access(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit drop_early);
        int lat;
        int unsigned wc;
        wc = sel ? 0 : 2;
        push_exp(sel, we, addr, wdata);
        if (sel) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
        else     begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
        @(posedge clk_pi);
        lat = 0;
        do begin
            @(negedge clk_pi);
            lat++;
            if (lat == 1) begin
                check_eq("busy_after_accept", 32'(sel ? busy_b : busy_a), 32'd1);
                if (drop_early) begin
                    if (sel) req_b = 1'b0;
                    else     req_a = 1'b0;
                end
            end
        end while (!(sel ? ack_b : ack_a) && lat < 20);
        check_eq("ack_latency", 32'(lat), 32'(wc + 1));
        if (sel) req_b = 1'b0;
        else     req_a = 1'b0;
        @(negedge clk_pi);
    endtask

    always @(negedge clk_pi) begin
        exp_t e;
        if (reset_n_pi) begin
            if (ack_a) begin
                if (q_a.size() == 0) begin
                    check_eq("a_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = q_a.pop_front();
                    check_eq("a_err", 32'(err_a), 32'(e.err));
                    check_eq("a_rdata", rdata_a, e.rdata);
                end
            end else begin
                check_eq("a_idle_quiet", rdata_a | 32'(err_a), 32'd0);
            end
            if (ack_b) begin
                if (q_b.size() == 0) begin
                    check_eq("b_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = q_b.pop_front();
                    check_eq("b_err", 32'(err_b), 32'(e.err));
                    check_eq("b_rdata", rdata_b, e.rdata);
                end
            end else begin
                check_eq("b_idle_quiet", rdata_b | 32'(err_b), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        addrs[0] = 32'h0000_0000; addrs[1] = 32'h0000_0004;
        addrs[2] = 32'h0000_0010; addrs[3] = 32'h0000_03FC;
        addrs[4] = 32'h0000_0400; addrs[5] = 32'h0000_0022;
        addrs[6] = 32'h0000_0002; addrs[7] = 32'h8000_0000;
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
        clear_models();
        reset_n_pi = 1'b0;
        repeat (3) @(negedge clk_pi);
        check_eq("rst_ack", 32'(ack_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        check_eq("rst_rdata", rdata_a, 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        reset_n_pi = 1'b1;
        @(negedge clk_pi);

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        access(0, 1'b0, 32'h10, 32'h0, 0);
        access(0, 1'b1, 32'h3FC, 32'h12345678, 0);
        access(0, 1'b0, 32'h3FC, 32'h0, 1);
        access(0, 1'b0, 32'h400, 32'h0, 0);
        access(0, 1'b1, 32'h400, 32'hFFFFFFFF, 0);
        access(0, 1'b0, 32'h0, 32'h0, 0);
        access(0, 1'b0, 32'h3FC, 32'h0, 0);
        access(0, 1'b1, 32'h22, 32'hFFFFFFFF, 0);
        access(0, 1'b0, 32'h20, 32'h0, 0);
        for (int i = 0; i < 24; i++) begin
            access(0, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom(),
                   1'($urandom_range(0, 1)));
        end

        // Zero-wait instance: store then load with req held high across the ack.
        push_exp(1, 1'b1, 32'h4, 32'hA5A5A5A5);
        req_b = 1'b1; we_b = 1'b1; addr_b = 32'h4; wdata_b = 32'hA5A5A5A5;
        @(posedge clk_pi);
        @(negedge clk_pi);
        check_eq("b2b_ack_first", 32'(ack_b), 32'd1);
        push_exp(1, 1'b0, 32'h4, 32'h0);
        we_b = 1'b0; wdata_b = '0;
        @(negedge clk_pi);
        check_eq("b2b_gap", 32'(ack_b), 32'd0);
        @(negedge clk_pi);
        check_eq("b2b_ack_second", 32'(ack_b), 32'd1);
        req_b = 1'b0;
        @(negedge clk_pi);
        access(1, 1'b0, 32'h4, 32'h0, 0);
        access(1, 1'b0, 32'h6, 32'h0, 0);

`ifdef DMEM_PERF_CNT_EN
        check_eq("load_cnt", load_cnt_a, 32'(m_load));
        check_eq("store_cnt", store_cnt_a, 32'(m_store));
        check_eq("err_cnt", 32'(err_cnt_a), 32'(m_err));
`endif

        // Reset during WAIT of a store to 0x8: dropped, no ack, memory cleared.
        access(0, 1'b1, 32'h8, 32'h13579BDF, 0);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h8; wdata_a = 32'h55555555;
        @(posedge clk_pi);
        @(negedge clk_pi);
        reset_n_pi = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
        check_eq("rst_mid_ack", 32'(ack_a), 32'd0);
        clear_models();
        req_a = 1'b0;
        #2;
        reset_n_pi = 1'b1;
`ifdef DMEM_PERF_CNT_EN
        check_eq("rst_load_cnt", load_cnt_a, 32'd0);
        check_eq("rst_store_cnt", store_cnt_a, 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt_a), 32'd0);
`endif
        repeat (6) @(negedge clk_pi);
        access(0, 1'b0, 32'h8, 32'h0, 0);
        access(0, 1'b0, 32'h10, 32'h0, 0);

        check_eq("a_queue_drained", 32'(q_a.size()), 32'd0);
        check_eq("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for load/store requests issued by the processor's MEM stage.
- Word-organised data store with a req/ack handshake and a programmable number of wait states.
- Lets the pipeline run against a multi-cycle memory. The initiator holds its request until ack.
- Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 2, wait states between accept and ack; 0..15.

Ports:
- clk_pi  input  1  clock; all state changes on rising edge.
- reset_n_pi  input  1  reset; asynchronous, active-low.
- req_pi  input  1  request valid; held with stable fields until ack_po.
- we_pi  input  1  1 = store, 0 = load.
- addr_pi  input  32  byte address.
- wdata_pi  input  32  store data.
- ack_po  output  1  one-cycle response strobe.
- rdata_po  output  32  load data; valid only while ack_po=1, 0 otherwise.
- err_po  output  1  qualifies ack_po; access rejected.
- busy_po  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n_pi=0, async):
  - FSM goes to IDLE; wait counter = 0.
  - ack_po=0, err_po=0, rdata_po=0, busy_po=0.
  - All memory words cleared to 0.
  - An in-flight store is dropped (no write). An in-flight load gets no ack.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with req_pi=1, capture we, addr and wdata into internal registers.
  - Go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go straight to RESP.
  - With req_pi=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - Go to RESP when the counter = 0.
  - Inputs are ignored; only captured values are used.
- RESP (exactly one cycle), then unconditionally back to IDLE:
  - ack_po=1.
  - Store: mem[idx] <= captured wdata at the end of the RESP cycle.
  - Load: rdata_po = mem[idx], driven registered/stable for the RESP cycle.
- Latency: ack_po is asserted WAIT_CYCLES+1 cycles after the edge that sampled req_pi.
- Index: idx = addr[log2(DEPTH)+1:2].
- Error condition: addr[1:0]≠0, or addr[31:log2(DEPTH)+2]≠0.
  - ack_po=1 and err_po=1 in RESP.
  - No write; rdata_po=0.
  - Timing is identical to a normal access.
- Handshake:
  - The initiator drops req_pi in the cycle after ack, or keeps it high to present a new request.
  - req_pi=1 in the IDLE cycle following RESP is a new access. Throughput is therefore at most one access per WAIT_CYCLES+2 cycles.
  - req_pi deasserted before ack: the request is still completed (it was already captured).
- Back-to-back store then load to the same address: the load returns the new data, because the write completes in RESP before the next accept.
- err_po and rdata_po are 0 whenever ack_po=0.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - Adds outputs load_cnt_po[31:0], store_cnt_po[31:0] and err_cnt_po[15:0].
  - Each increments in the RESP cycle of a successful load, a successful store, or an errored access, respectively.
  - Counters wrap modulo 2^width and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then store addr=0x10 data=0xDEADBEEF with WAIT_CYCLES=2 → ack_po high exactly 3 cycles after accept, err_po=0. A subsequent load from 0x10 → rdata_po=0xDEADBEEF during ack.
- Load addr=0x3FC (last word, DEPTH=256) after storing 0x12345678 there → 0x12345678. Load addr=0x400 → ack with err_po=1, rdata_po=0, memory unchanged.
- Store addr=0x22 (misaligned) data=0xFFFFFFFF → err_po=1. A load from 0x20 returns its prior value 0.
- Reset pulsed low during WAIT of a store to 0x8 → no ack, busy_po=0 immediately, and a later load from 0x8 returns 0.
- WAIT_CYCLES=0, back-to-back store 0x4=0xA5A5A5A5 then load 0x4 with req_pi held high → ack on consecutive-access spacing of 2 cycles, load returns 0xA5A5A5A5.
- With DMEM_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned → load_cnt_po=3, store_cnt_po=2, err_cnt_po=1. After reset, all counters are 0.
